// File: rtl/usrt_rx_buffer_pkg.sv
// usrt_rx_buffer_pkg: shared widths, depth and FSM state encoding for the USRT receive buffer
package usrt_rx_buffer_pkg;
  localparam int USRT_DATA_W    = 8;
  localparam int USRT_RXB_DEPTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, WAIT_REL = 2'd2} state_e;
endpackage

// File: rtl/usrt_sync_fifo.sv
// usrt_sync_fifo: first-word fall-through FIFO; write+read at full is allowed, read on empty ignored
module usrt_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_wr, do_rd;
  assign empty   = count_q == '0;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // pointers wrap naturally; occupancy tracks net writes minus reads
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, do_wr};
      rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, do_rd};
      count_q  <= count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
  // storage needs no reset; contents are only visible when non-empty
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/usrt_rx_buffer.sv
// usrt_rx_buffer: captures Reciever bytes on ninti, acks with read, queues for host; USRT_RXB_OVERFLOW_EN drops-and-flags when full
module usrt_rx_buffer
  import usrt_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = USRT_RXB_DEPTH,
  parameter int DATA_W = USRT_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ninti,
  input  logic [DATA_W-1:0]      show,
  output logic                   read,
  output logic                   ien,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
`ifdef USRT_RXB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic   drop_q, drop_d, ien_q, ien_d, ovf_q, ovf_d;
  usrt_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (state_q == CAPTURE && !drop_q),
    .wr_data (show),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );
  assign read     = state_q == CAPTURE;
  assign ien      = ien_q;
  assign overflow = ovf_q;
  // one capture per ninti low level; a capture started while full is a drop
  always_comb begin
    state_d = state_q == IDLE    ? ((!ninti && (!full || OVF_EN)) ? CAPTURE : IDLE) :
              state_q == CAPTURE ? WAIT_REL :
              (ninti ? IDLE : WAIT_REL);
    drop_d  = state_q == IDLE ? full : drop_q;
    ovf_d   = ovf_q | (OVF_EN && state_q == IDLE && !ninti && full);
    ien_d   = OVF_EN | !full;
  end
  // state, drop marker, sticky overflow and registered receive enable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ien_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      ien_q   <= ien_d;
    end
  end
endmodule
